uart_tx_mmio: RTL

//  Memory-mapped UART transmitter: the peripheral end of CPU6 byte writes to the console port.

---
 rtl/uart_tx_mmio_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/uart_tx_mmio.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// status register bit positions and the default bus address.
package uart_tx_mmio_pkg;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h5a00;

    localparam int ST_SHIFTING = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_EMPTY    = 2;
    localparam int ST_OVF      = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with one extra pointer bit to separate full from empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               push_data,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: bus decode, status register, TX FIFO and serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); otherwise frames are 8N1.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;

    tx_state_t     state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          overflow;

    logic          hit_data;
    logic          hit_stat;
    logic          push;
    logic          ovf_clr;
    logic          bit_end;
    logic          shifting;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_data;
    logic [AW:0]   fifo_count;
    logic [7:0]    status;

    assign hit_data = (address == BASE_ADDR);
    assign hit_stat = (address == STAT_ADDR);
    assign sel      = (address[15:1] == BASE_ADDR[15:1]);
    assign push     = write_en && hit_data;
    assign ovf_clr  = write_en && hit_stat && data_in[ST_OVF];
    assign bit_end  = (clk_cnt == LAST_CLK);
    assign shifting = (state != S_IDLE);
    assign busy     = shifting || !fifo_empty;
    // Pop on the idle->start edge, or at the last clock of STOP for back-to-back frames.
    assign fifo_pop = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (fifo_pop),
        .push_data(data_in),
        .pop_data (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        status               = 8'h00;
        status[ST_SHIFTING]  = shifting;
        status[ST_FULL]      = fifo_full;
        status[ST_EMPTY]     = fifo_empty;
        status[ST_OVF]       = overflow;
        data_out             = 8'h00;
        if (hit_data)      data_out = 8'(fifo_count);
        else if (hit_stat) data_out = status;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tx        <= 1'b1;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_pop) begin
                        shift_reg <= fifo_data;
                        state     <= S_START;
                        tx        <= 1'b0;
                        clk_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= S_DATA;
                        tx      <= shift_reg[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= even_parity(shift_reg);
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= S_STOP;
                        tx      <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (fifo_pop) begin
                            shift_reg <= fifo_data;
                            state     <= S_START;
                            tx        <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
